// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, overflow, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, overflow, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one full-adder cell
// computing a + ~b + 1 with a registered carry. Multi-cycle start/busy/done unit.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_res, r_diff;
  logic [CW-1:0]    r_count;
  logic             r_c, r_borrow, r_overflow, r_zero;

  logic             w_nb, w_s, w_c_next, w_accept, w_last;
  logic [WIDTH-1:0] w_diff_final;

  always_comb begin
    w_nb         = ~r_b_sh[0];
    w_s          = r_a_sh[0] ^ w_nb ^ r_c;
    w_c_next     = (r_a_sh[0] & w_nb) | (r_c & (r_a_sh[0] ^ w_nb));
    w_diff_final = {w_s, r_res[WIDTH-1:1]};
    w_accept     = bus.start && (r_state != StRun);
    w_last       = (r_state == StRun) && (r_count == CW'(WIDTH - 1));
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (bus.start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = bus.start ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_res      <= '0;
      r_diff     <= '0;
      r_count    <= '0;
      r_c        <= 1'b0;
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a_sh  <= bus.a;
        r_b_sh  <= bus.b;
        r_res   <= '0;
        r_c     <= 1'b1;
        r_count <= '0;
      end else if (r_state == StRun) begin
        r_a_sh  <= r_a_sh >> 1;
        r_b_sh  <= r_b_sh >> 1;
        r_res   <= w_diff_final;
        r_c     <= w_c_next;
        r_count <= r_count + CW'(1);
        if (w_last) begin
          // Signed overflow: carry into the MSB differs from carry out of it.
          r_diff     <= w_diff_final;
          r_borrow   <= ~w_c_next;
          r_overflow <= r_c ^ w_c_next;
          r_zero     <= (w_diff_final == '0);
        end
      end
    end
  end

  assign bus.busy     = (r_state == StRun);
  assign bus.done     = (r_state == StDone);
  assign bus.diff     = r_diff;
  assign bus.borrow   = r_borrow;
  assign bus.overflow = r_overflow;
  assign bus.zero     = r_zero;
endmodule
